// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default
// CTS timeout and an index-width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CTS = 2'd1,
        SEND     = 2'd2,
        BUSY     = 2'd3
    } uart_state_t;

    localparam int CTS_TIMEOUT_DEFAULT = 1023;

    // Width of an index into n requesters; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, with wrap.
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [PW-1:0]    idx
);

    localparam int SW = PW + 1;

    logic [PW-1:0]    cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_hit;

    // Candidate gi is the requester gi positions above ptr, modulo N_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [SW-1:0] sum;
            assign sum          = {1'b0, ptr} + SW'(gi);
            assign cand_idx[gi] = (sum >= SW'(N_REQ)) ? PW'(sum - SW'(N_REQ)) : PW'(sum);
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        idx    = '0;
        onehot = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                idx = cand_idx[k];
            end
        end
        if (|cand_hit) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters,
// with RTS/CTS handshaking and a bounded wait for CTS.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int CTS_TIMEOUT = CTS_TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   err,
    output logic [N_REQ-1:0]   grant,
    output logic               rts_n,
    input  logic               cts_n,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_done
);

    localparam int PW = idx_width(N_REQ);
    localparam int TW = $clog2(CTS_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LIMIT = TW'(CTS_TIMEOUT);
    localparam logic [PW-1:0] LAST_IDX    = PW'(N_REQ - 1);

    uart_state_t      state_reg,   state_next;
    logic [N_REQ-1:0] grant_reg,   grant_next;
    logic [PW-1:0]    owner_reg,   owner_next;
    logic [PW-1:0]    ptr_reg,     ptr_next;
    logic [TW-1:0]    timer_reg,   timer_next;
    logic [7:0]       tx_data_reg, tx_data_next;
    logic             rts_n_reg,   rts_n_next;
    logic [N_REQ-1:0] ack_reg,     ack_next;
    logic [N_REQ-1:0] err_reg,     err_next;

    logic [N_REQ-1:0] pick_onehot;
    logic [PW-1:0]    pick_idx;
    logic [PW-1:0]    owner_inc;
    logic [7:0]       req_byte [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_byte
            assign req_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    // Search restarts just past whoever finished last, whether by ack or err.
    assign owner_inc = (owner_reg == LAST_IDX) ? '0 : owner_reg + PW'(1);

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        owner_next   = owner_reg;
        ptr_next     = ptr_reg;
        timer_next   = timer_reg;
        tx_data_next = tx_data_reg;
        rts_n_next   = rts_n_reg;
        ack_next     = '0;
        err_next     = '0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    grant_next   = pick_onehot;
                    owner_next   = pick_idx;
                    tx_data_next = req_byte[pick_idx];
                    rts_n_next   = 1'b0;
                    timer_next   = '0;
                    state_next   = WAIT_CTS;
                end
            end
            WAIT_CTS: begin
                if (!cts_n) begin
                    state_next = SEND;
                end else if (timer_reg == TIMER_LIMIT) begin
                    err_next   = grant_reg;
                    rts_n_next = 1'b1;
                    grant_next = '0;
                    ptr_next   = owner_inc;
                    state_next = IDLE;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            SEND: begin
                state_next = BUSY;
            end
            BUSY: begin
                if (tx_done) begin
                    ack_next   = grant_reg;
                    rts_n_next = 1'b1;
                    grant_next = '0;
                    ptr_next   = owner_inc;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            owner_reg   <= '0;
            ptr_reg     <= '0;
            timer_reg   <= '0;
            tx_data_reg <= '0;
            rts_n_reg   <= 1'b1;
            ack_reg     <= '0;
            err_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            owner_reg   <= owner_next;
            ptr_reg     <= ptr_next;
            timer_reg   <= timer_next;
            tx_data_reg <= tx_data_next;
            rts_n_reg   <= rts_n_next;
            ack_reg     <= ack_next;
            err_reg     <= err_next;
        end
    end

    assign grant    = grant_reg;
    assign ack      = ack_reg;
    assign err      = err_reg;
    assign rts_n    = rts_n_reg;
    assign tx_data  = tx_data_reg;
    assign tx_start = (state_reg == SEND);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: scenario tasks plus a randomized run checked against
// a round-robin reference model and a simple far-end link / transmitter model.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int TO = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [8*N-1:0]   req_data = '0;
    logic [N-1:0]     ack, err, grant;
    logic             rts_n;
    logic             cts_n = 1'b1;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_done = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .N_REQ       (N),
        .CTS_TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .err      (err),
        .grant    (grant),
        .rts_n    (rts_n),
        .cts_n    (cts_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done)
    );

    int checks  = 0;
    int errors  = 0;
    int mdl_ptr = 0;

    // Far-end receiver and UART transmitter behaviour, updated just after each edge.
    bit cts_auto  = 1'b1;
    int cts_delay = 2;
    int tx_lat    = 3;
    bit cts_drop  = 1'b0;
    bit stray_en  = 1'b0;
    int rts_low_cnt = 0;
    int done_cnt    = 0;
    bit in_flight   = 1'b0;

    always begin
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        if (rst) begin
            rts_low_cnt = 0;
            done_cnt    = 0;
            in_flight   = 1'b0;
            cts_n       = 1'b1;
        end else begin
            rts_low_cnt = rts_n ? 0 : rts_low_cnt + 1;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    tx_done   = 1'b1;
                    in_flight = 1'b0;
                end
            end else if (tx_start) begin
                done_cnt  = tx_lat;
                in_flight = 1'b1;
            end else if (stray_en && !in_flight && $urandom_range(3) == 0) begin
                tx_done = 1'b1;
            end
            cts_n = !(cts_auto && !rts_n && rts_low_cnt >= cts_delay && !(cts_drop && in_flight));
        end
    end

    // Protocol invariants accumulated over the whole run.
    int   viol = 0;
    logic tx_start_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(ack) > 1 || $countones(err) > 1 || (|ack && |err) ||
                $countones(grant) > 1 || ((grant != '0) == rts_n) ||
                (tx_start && tx_start_prev)) begin
                viol <= viol + 1;
            end
        end
        tx_start_prev <= tx_start;
    end

    function automatic int rr_model(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_byte(input int i, input logic [7:0] b);
        req_data[8*i +: 8] = b;
    endtask

    task automatic wait_grant(output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (grant != '0) got = 1'b1;
        end
    endtask

    task automatic wait_done(output bit got, output logic [N-1:0] a, output logic [N-1:0] e,
                             output int n_start, output logic [7:0] sent, output int cyc);
        got = 1'b0; a = '0; e = '0; n_start = 0; sent = '0; cyc = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (tx_start) begin
                n_start++;
                sent = tx_data;
            end
            if (ack != '0 || err != '0) begin
                got = 1'b1;
                a   = ack;
                e   = err;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        checks++; if (grant !== '0)   begin errors++; $display("FAIL reset_grant: got %b want 0", grant); end
        checks++; if (ack !== '0)     begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
        checks++; if (err !== '0)     begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (rts_n !== 1'b1) begin errors++; $display("FAIL reset_rts_n: got %b want 1", rts_n); end
        rst = 1'b0;
        mdl_ptr = 0;
        repeat (2) @(negedge clk);
        checks++; if (grant !== '0 || rts_n !== 1'b1) begin
            errors++; $display("FAIL idle_no_req: grant %b rts_n %b want 0/1", grant, rts_n);
        end
        $display("txn reset: outputs at reset values");
    endtask

    task automatic test_single();
        bit got; int cyc, n, done_at, ack_at; logic [7:0] sent; logic [N-1:0] a;
        cts_auto = 1'b1; cts_delay = 2; tx_lat = 3;
        for (int i = 0; i < N; i++) set_byte(i, 8'($urandom));
        set_byte(2, 8'hA5);
        req = 4'b0100;
        @(negedge clk);
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", grant); end
        checks++; if (rts_n !== 1'b0) begin errors++; $display("FAIL single_rts_n: got %b want 0", rts_n); end
        n = 0; done_at = -1; ack_at = -1; sent = '0; a = '0;
        for (int c = 0; c < 60 && ack_at < 0; c++) begin
            @(negedge clk);
            if (tx_start) begin n++; sent = tx_data; end
            if (tx_done) done_at = c;
            if (ack != '0) begin ack_at = c; a = ack; end
        end
        req = '0;
        checks++; if (n !== 1 || sent !== 8'hA5) begin
            errors++; $display("FAIL single_tx: starts %0d byte %h want 1 / a5", n, sent);
        end
        checks++; if (a !== 4'b0100 || ack_at < 0 || ack_at !== done_at + 1) begin
            errors++; $display("FAIL single_ack: ack %b at %0d done at %0d want 0100 one cycle after done", a, ack_at, done_at);
        end
        mdl_ptr = 3;
        @(negedge clk);
        checks++; if (grant !== '0 || rts_n !== 1'b1) begin
            errors++; $display("FAIL single_release: grant %b rts_n %b want 0/1", grant, rts_n);
        end
        $display("txn single: grant 0100 byte %h", sent);
    endtask

    task automatic test_req_drop();
        bit got; int cyc, n; logic [7:0] sent, b; logic [N-1:0] a, e;
        b = 8'($urandom);
        set_byte(3, b);
        req = 4'b1000;
        wait_grant(got, cyc);
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL drop_grant: got %b want 1000", grant); end
        @(negedge clk);
        req = '0;
        wait_done(got, a, e, n, sent, cyc);
        checks++; if (!got || a !== 4'b1000 || e !== '0 || n !== 1 || sent !== b) begin
            errors++; $display("FAIL drop_ack: ack %b err %b starts %0d byte %h want 1000/0000/1/%h", a, e, n, sent, b);
        end
        mdl_ptr = 0;
        $display("txn req_drop: ack %b byte %h", a, sent);
    endtask

    task automatic test_timeout();
        bit got; int cyc, n, x, y; logic [7:0] sent; logic [N-1:0] a, e;
        cts_auto = 1'b0;
        for (int i = 0; i < N; i++) set_byte(i, 8'($urandom));
        req = 4'b0011;
        x = rr_model(req, mdl_ptr);
        wait_grant(got, cyc);
        checks++; if (grant !== oh(x)) begin errors++; $display("FAIL timeout_grant: got %b want %b", grant, oh(x)); end
        wait_done(got, a, e, n, sent, cyc);
        checks++; if (!got || e !== oh(x) || a !== '0 || n !== 0 || cyc !== TO + 1) begin
            errors++; $display("FAIL timeout_err: err %b ack %b starts %0d after %0d cycles want %b/0/0/%0d", e, a, n, cyc, oh(x), TO + 1);
        end
        checks++; if (rts_n !== 1'b1 || grant !== '0) begin
            errors++; $display("FAIL timeout_release: rts_n %b grant %b want 1/0", rts_n, grant);
        end
        cts_auto = 1'b1;
        mdl_ptr = (x + 1) % N;
        y = rr_model(req, mdl_ptr);
        wait_grant(got, cyc);
        checks++; if (grant !== oh(y)) begin errors++; $display("FAIL timeout_next_grant: got %b want %b", grant, oh(y)); end
        wait_done(got, a, e, n, sent, cyc);
        req = '0;
        checks++; if (a !== oh(y) || sent !== req_data[8*y +: 8]) begin
            errors++; $display("FAIL timeout_next_ack: ack %b byte %h want %b/%h", a, sent, oh(y), req_data[8*y +: 8]);
        end
        mdl_ptr = (y + 1) % N;
        $display("txn timeout: err on %0d then ack on %0d", x, y);
    endtask

    task automatic test_reset_mid();
        bit got, seen_ack; int cyc, x;
        tx_lat = 12;
        set_byte(0, 8'h3C);
        req = 4'b0001;
        x = rr_model(req, mdl_ptr);
        wait_grant(got, cyc);
        checks++; if (grant !== oh(x)) begin errors++; $display("FAIL rmid_grant: got %b want %b", grant, oh(x)); end
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (tx_start) got = 1'b1;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (grant !== '0 || ack !== '0 || err !== '0 || tx_start !== 1'b0 ||
                      tx_data !== 8'h00 || rts_n !== 1'b1) begin
            errors++; $display("FAIL rmid_outputs: grant %b ack %b err %b start %b data %h rts_n %b want all reset values",
                               grant, ack, err, tx_start, tx_data, rts_n);
        end
        seen_ack = 1'b0;
        repeat (2) begin @(negedge clk); if (ack != '0 || err != '0) seen_ack = 1'b1; end
        rst = 1'b0;
        req = 4'b1010;
        mdl_ptr = 0;
        x = rr_model(req, mdl_ptr);
        tx_lat = 3;
        @(negedge clk);
        if (ack != '0 || err != '0) seen_ack = 1'b1;
        checks++; if (seen_ack) begin errors++; $display("FAIL rmid_no_ack: got ack/err pulse want none"); end
        checks++; if (grant !== oh(x)) begin errors++; $display("FAIL rmid_first_grant: got %b want %b", grant, oh(x)); end
        begin
            int n; logic [7:0] sent; logic [N-1:0] a, e;
            wait_done(got, a, e, n, sent, cyc);
            req = '0;
            mdl_ptr = (x + 1) % N;
        end
        $display("txn reset_mid: first grant after release %b", oh(x));
    endtask

    task automatic test_fairness();
        bit got; int cyc, n, x; logic [7:0] sent; logic [N-1:0] a, e;
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mdl_ptr = 0;
        for (int i = 0; i < N; i++) set_byte(i, 8'($urandom));
        req = 4'b1111;
        for (int k = 0; k < 2 * N; k++) begin
            x = rr_model(req, mdl_ptr);
            wait_grant(got, cyc);
            checks++; if (grant !== oh(x)) begin
                errors++; $display("FAIL fair_grant_%0d: got %b want %b", k, grant, oh(x));
            end
            wait_done(got, a, e, n, sent, cyc);
            if (k == 2 * N - 1) req = '0;
            checks++; if (a !== oh(x) || sent !== req_data[8*x +: 8]) begin
                errors++; $display("FAIL fair_ack_%0d: ack %b byte %h want %b/%h", k, a, sent, oh(x), req_data[8*x +: 8]);
            end
            mdl_ptr = (x + 1) % N;
            $display("txn fair %0d: grant %0d", k, x);
        end
    endtask

    task automatic test_random();
        bit got; int cyc, n, x; logic [7:0] sent, exp_b; logic [N-1:0] a, e;
        stray_en = 1'b1;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(1) == 1) begin req[i] = 1'b1; set_byte(i, 8'($urandom)); end
        end
        if (req == '0) begin req[0] = 1'b1; set_byte(0, 8'($urandom)); end
        for (int t = 0; t < 40; t++) begin
            cts_auto  = ($urandom_range(4) != 0);
            cts_delay = $urandom_range(1, 5);
            tx_lat    = $urandom_range(1, 6);
            cts_drop  = $urandom_range(1);
            x = rr_model(req, mdl_ptr);
            exp_b = req_data[8*x +: 8];
            wait_grant(got, cyc);
            checks++; if (!got || grant !== oh(x)) begin
                errors++; $display("FAIL rand_grant_%0d: got %b want %b", t, grant, oh(x));
            end
            for (int i = 0; i < N; i++) begin
                if (i != x && !req[i] && $urandom_range(2) == 0) begin
                    req[i] = 1'b1; set_byte(i, 8'($urandom));
                end
            end
            if ($urandom_range(2) == 0) req[x] = 1'b0;
            wait_done(got, a, e, n, sent, cyc);
            req[x] = 1'b0;
            if (cts_auto) begin
                checks++; if (!got || a !== oh(x) || e !== '0 || n !== 1 || sent !== exp_b) begin
                    errors++; $display("FAIL rand_ack_%0d: ack %b err %b starts %0d byte %h want %b/0000/1/%h", t, a, e, n, sent, oh(x), exp_b);
                end
            end else begin
                checks++; if (!got || e !== oh(x) || a !== '0 || n !== 0) begin
                    errors++; $display("FAIL rand_err_%0d: err %b ack %b starts %0d want %b/0000/0", t, e, a, n, oh(x));
                end
            end
            $display("txn rand %0d: owner %0d %s byte %h", t, x, cts_auto ? "ack" : "err", exp_b);
            mdl_ptr = (x + 1) % N;
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(1) == 1) begin req[i] = 1'b1; set_byte(i, 8'($urandom)); end
            end
            if (req == '0) begin req[$urandom_range(N - 1)] = 1'b1; end
        end
        req = '0;
        stray_en = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (viol !== 0) begin
            errors++; $display("FAIL invariants: %0d violating cycles want 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_req_drop();
        test_timeout();
        test_reset_mid();
        test_fairness();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter CTS_TIMEOUT, default 1023, meaning the maximum number of cycles spent waiting for CTS before abandoning a transfer.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  N_REQ  per-requester transfer request, level, held until ack or err.
REQ-006 SHALL have port req_data  input  8*N_REQ  byte per requester; requester i occupies bits [8i+7:8i].
REQ-007 SHALL have port ack  output  N_REQ  one-cycle pulse on the granted bit when its byte has been sent.
REQ-008 SHALL have port err  output  N_REQ  one-cycle pulse on the granted bit on CTS timeout.
REQ-009 SHALL have port grant  output  N_REQ  one-hot current owner; all zeros when idle.
REQ-010 SHALL have port rts_n  output  1  request-to-send to link, active low.
REQ-011 SHALL have port cts_n  input  1  clear-to-send from far-end receiver, active low.
REQ-012 SHALL have port tx_start  output  1  one-cycle pulse to the UART transmitter.
REQ-013 SHALL have port tx_data  output  8  byte to transmit, valid while tx_start is high and held until the next grant.
REQ-014 SHALL have port tx_done  input  1  one-cycle pulse from the transmitter after the stop bit.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_CTS, SEND, BUSY.
REQ-016 IDLE: when any req bit is set, SHALL grant the first set bit searching upward (with wrap) from ptr, where ptr is the index after the last granted requester.
- On grant: latch that requester's byte into tx_data, set grant one-hot, drive rts_n=0, clear the timer, go to WAIT_CTS.
- Grant decision and grant/rts_n outputs are registered: one cycle of latency from req to grant.
REQ-017 WAIT_CTS: if cts_n==0, SHALL go to SEND.
- Otherwise, when the timer equals CTS_TIMEOUT: pulse err on the granted bit, drive rts_n=1, clear grant, set ptr=granted+1 mod N_REQ, go to IDLE.
- Otherwise increment the timer (width clog2(CTS_TIMEOUT+1), no wrap).
REQ-018 SEND: SHALL pulse tx_start for exactly one cycle, then go to BUSY.
REQ-019 BUSY: on tx_done, SHALL:
- pulse ack on the granted bit;
- drive rts_n=1;
- clear grant;
- set ptr=granted+1 mod N_REQ;
- go to IDLE.
REQ-020 After returning to IDLE, SHALL wait at least one cycle before the next grant, so rts_n is high for at least one cycle between transfers.
REQ-021 req deassertion by the owner after grant SHALL be ignored; the latched byte is still sent and ack still pulses.
REQ-022 cts_n deassertion during SEND/BUSY SHALL be ignored; the byte in flight completes.
REQ-023 tx_done outside BUSY SHALL be ignored.
REQ-024 ack and err SHALL never both be high in the same cycle, and at most one bit of each SHALL be high at a time.
REQ-025 With all N_REQ bits continuously requesting, each requester SHALL be granted exactly once per N_REQ transfers.

Reset
REQ-026 While rst is high, SHALL force: state=IDLE, ptr=0, grant=0, ack=0, err=0, tx_start=0, tx_data=0, rts_n=1, timer=0.
REQ-027 Reset asserted mid-transfer SHALL abort immediately, with no ack or err; the first grant after release searches from index 0.

Structure
REQ-028 FSM state encodings and the default CTS_TIMEOUT SHALL live in shared package uart_pkg.
REQ-029 The round-robin priority search SHALL be the sub-module rr_pick: inputs req and ptr; outputs one-hot and index; combinational.

Verification
REQ-030 Single requester: req=4'b0100 with byte 0xA5; cts_n=0 two cycles after rts_n falls -> grant=4'b0100, one tx_start with tx_data=0xA5, ack=4'b0100 one cycle after tx_done.
REQ-031 Fairness: req=4'b1111 held for 8 transfers -> grant order 0,1,2,3,0,1,2,3.
REQ-032 Timeout: CTS_TIMEOUT=15, cts_n held high -> err pulses on the granted bit 16 cycles after the grant; rts_n returns high; the next grant is the following requester.
REQ-033 Owner drops req the cycle after grant -> transfer completes and ack still pulses.
REQ-034 rst pulsed during BUSY -> all outputs at reset values the same cycle, no ack; with req=4'b1010 after release, the first grant is 4'b0010.
